// File: rtl/alu_pkg.sv
// =============================================================================
// Module      : alu_pkg
// Description : Shared ALU types and helpers: normalizer state encoding and the
//               count-width helper used to size shift-amount fields.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_norm_state_t;

    // Bits needed to represent every shift amount 0..n inclusive.
    function automatic int alu_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_normalize_fsm.sv
// =============================================================================
// Module      : alu_normalize_fsm
// Description : Control FSM for the sequential normalizer; owns the state
//               register and the registered busy/done flags.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_normalize_fsm
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       work_zero,
    input  logic       work_msb,
    output logic [1:0] state,
    output logic       busy,
    output logic       done
);

    alu_norm_state_t r_state;
    alu_norm_state_t w_next;
    logic            r_busy;
    logic            r_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_SHIFT;
            ST_SHIFT: if (work_zero || work_msb) w_next = ST_DONE;
            ST_DONE:  w_next = start ? ST_SHIFT : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Flags are registered from the next state so they track the state
    // register exactly without any combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_SHIFT);
            r_done  <= (w_next == ST_DONE);
        end
    end

    assign state = r_state;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

`default_nettype wire

// File: rtl/alu_normalize_seq.sv
// =============================================================================
// Module      : alu_normalize_seq
// Description : Sequential normalizer; shifts the operand left one bit per clock
//               until the MSB is set and reports the shift count (CLZ).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_normalize_seq
    import alu_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = alu_cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  A,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  Z,
    output logic [CW-1:0] S,
    output logic          zero
);

    logic [1:0]    w_state;
    logic          w_load;
    logic          w_in_shift;
    logic          w_work_zero;
    logic          w_work_msb;

    logic [N-1:0]  r_work;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_z;
    logic [CW-1:0] r_s;
    logic          r_zero;

    alu_normalize_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .work_zero (w_work_zero),
        .work_msb  (w_work_msb),
        .state     (w_state),
        .busy      (busy),
        .done      (done)
    );

    // A request is honoured from IDLE and also from DONE for back-to-back use.
    assign w_load      = start && ((w_state == ST_IDLE) || (w_state == ST_DONE));
    assign w_in_shift  = (w_state == ST_SHIFT);
    assign w_work_zero = (r_work == '0);
    assign w_work_msb  = r_work[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_z    <= '0;
            r_s    <= '0;
            r_zero <= 1'b0;
        end else if (w_load) begin
            r_work <= A;
            r_cnt  <= '0;
        end else if (w_in_shift) begin
            if (w_work_zero) begin
                r_z    <= '0;
                r_s    <= CW'(N);
                r_zero <= 1'b1;
            end else if (w_work_msb) begin
                r_z    <= r_work;
                r_s    <= r_cnt;
                r_zero <= 1'b0;
            end else begin
                r_work <= {r_work[N-2:0], 1'b0};
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    assign Z    = r_z;
    assign S    = r_s;
    assign zero = r_zero;

endmodule

`default_nettype wire

// File: doc/alu_normalize_seq.md
# alu_normalize_seq

Sequential normalizer: the inverse of the ALU barrel shifter. Given an N-bit operand, it left-shifts one bit per clock until the MSB is set. It returns the normalized value together with the shift amount that recovers it, so shifting `Z` right by `S` reproduces `A`. It sits beside the barrel shifter in the ALU datapath and serves count-leading-zeros and normalize operations through a start/done handshake.

## Interface
Parameters:
- `N`, default 4: operand width; N ≥ 2.
- `CW`, default `$clog2(N+1)` (3 for N=4): width of the shift-count output. Must hold the value N.

Ports:
- `clk`, input, 1: sole clock; rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request. Sampled on a rising edge only while not busy.
- `A`, input, N: operand, captured on the edge that accepts `start`.
- `busy`, output, 1: high while an operation is in progress.
- `done`, output, 1: one-cycle pulse when a result is valid.
- `Z`, output, N: normalized result.
- `S`, output, CW: shift count, equal to the number of leading zeros of `A`.
- `zero`, output, 1: set when `A` was 0.

## Operation
- States: IDLE, SHIFT, DONE. Two-bit encoding.
- **IDLE**, with `start` = 1:
  - Load `A` into the working register `r`; clear the counter `c`.
  - Go to SHIFT.
- **SHIFT**, on each edge:
  - If `r` = 0: set `Z`=0, `S`=N, `zero`=1; go to DONE.
  - Else if `r[N-1]` = 1: set `Z`=r, `S`=c, `zero`=0; go to DONE.
  - Else: `r` ← `r` << 1 (zero fill), `c` ← `c`+1.
- **DONE**, lasts one cycle with `done` = 1:
  - If `start` = 1, accept it: load as in IDLE and go to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- `start` asserted in SHIFT is ignored. It is not queued.
- `Z`, `S` and `zero` change only on the edge that enters DONE. They hold until the next such edge, including through later SHIFT cycles.
- Arithmetic:
  - `c` never exceeds N-1 inside SHIFT.
  - `S` = N occurs only for a zero operand.
  - All values are unsigned, and the shift is logical.

## Timing
- Reset, asynchronous and taking effect immediately:
  - State goes to IDLE.
  - `busy`=0, `done`=0, `Z`=0, `S`=0, `zero`=0.
  - `r` and `c` are cleared.
- Reset mid-operation abandons the operation silently: no `done` pulse.
- First accepted `start` after reset deassertion: the same rules as IDLE.
- `busy` = 1 exactly while in SHIFT. `done` = 1 exactly while in DONE. Both are registered with no combinational path from inputs.
- Latency, with the start edge as E0:
  - Nonzero `A` with k leading zeros: the edge that enters DONE is E(k+1). `done` is high in the cycle after E(k+1).
  - Zero `A`: DONE is entered at E1.
  - Worst case is E(N), for `A` = 1.
- Throughput: one result per k+2 cycles when `start` is re-asserted in DONE.
- `A` need not be held after E0.

## Structure
- Shared package `alu_pkg`:
  - State enum/localparams `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
  - A count-width helper used to size `CW`, also usable by the barrel shifter.
- Single sub-module `alu_normalize_fsm`: next-state logic and the `busy`/`done` registers.
- Datapath (`r`, `c`, output registers) lives in the top module.

## Test plan
(N=4; cycle counts measured from the start edge E0.)
- `A`=0001 → `done` after E4; `Z`=1000, `S`=3 (011), `zero`=0. `busy` high for 4 cycles.
- `A`=1010 → `done` after E1; `Z`=1010, `S`=0, `zero`=0.
- `A`=0000 → `done` after E1; `Z`=0000, `S`=4 (100), `zero`=1.
- `A`=0011 is started. `start` with `A`=1111 is pulsed at E1 while busy → ignored; the result is `Z`=1100, `S`=2. Then `start` is held in the DONE cycle with `A`=0100 → accepted; the next result is `Z`=1000, `S`=1 with no IDLE gap.
- Reset:
  - Assert `rst_n`=0 mid-SHIFT on an `A`=0001 operation → `busy`, `done`, `Z`, `S`, `zero` are all 0 immediately, with no `done` pulse.
  - After release, `A`=0110 → `Z`=1100, `S`=1.
- Sweep all 16 values of `A` back-to-back. Check each result:
  - `S` equals the leading-zero count.
  - `Z` >> `S` equals `A`.
  - For nonzero `A`, `Z[3]` = 1.
